// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
//   XLEN      : architectural word width
//   INSTR_NOP : instruction returned alongside an error response (addi x0,x0,0)
//   rsp_t     : one fetch response as it travels through pipeline and queue
package imem_fetch_responder_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } rsp_t;

endpackage

// File: rtl/imem_fetch_responder_sync_fifo.sv
// Synchronous FIFO used as the fetch response queue.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers only)
//   push_i/wdata_i: write an entry (ignored when full unless popping the same cycle)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the FIFO; a push in the same cycle is discarded
//   rdata_o       : head entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
module imem_fetch_responder_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign rdata_o = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: memory end of the core's fetch interface.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr: word fetch request (byte address)
//   rsp_valid/rsp_ready        : in-order response handshake
//   rsp_data/rsp_err           : instruction word, misaligned/out-of-range flag
//   flush                      : drop every outstanding and queued response
//   load_en/load_addr/load_data: program-load write port into the RAM
// Flow: request stage -> LATENCY-1 pipeline registers -> response queue -> output
// register. The queue is bypassed when it is empty and the output is free.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  input  logic            flush,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CW    = $clog2(QUEUE_DEPTH + 1);
  localparam int NPIPE = LATENCY - 1;

  logic [XLEN-1:0] ram_q [DEPTH_WORDS];

  logic [CW-1:0] count_q, count_d;
  logic          accept, pop_hs;
  logic          req_bad, load_ok;
  rsp_t          req_rsp, tail_rsp, fifo_rdata, rsp_q, rsp_d;
  logic          tail_vld, tail_take;
  logic          rsp_valid_q, rsp_valid_d;
  logic          out_free, q_empty;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic          unused_ok;

  assign req_ready = (count_q < CW'(QUEUE_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop_hs    = rsp_valid_q && rsp_ready;

  // Any set bit above the word index puts the address outside the RAM.
  assign req_bad      = (|req_addr[1:0]) || (|req_addr[XLEN-1:AW+2]);
  assign req_rsp.err  = req_bad;
  assign req_rsp.data = req_bad ? INSTR_NOP : ram_q[req_addr[AW+1:2]];

  assign load_ok   = load_en && !(|load_addr[XLEN-1:AW+2]);
  assign unused_ok = ^{load_addr[1:0], fifo_full};

  // The read above samples the old word, so a same-cycle load is read-before-write.
  always_ff @(posedge clk) begin
    if (load_ok) ram_q[load_addr[AW+1:2]] <= load_data;
  end

  if (LATENCY == 1) begin : g_nopipe
    assign tail_vld = accept;
    assign tail_rsp = req_rsp;
  end else begin : g_pipe
    logic [NPIPE-1:0] pv_q;
    rsp_t             pd_q [NPIPE];

    // Stage 0 captures the request even during flush; later stages are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= accept;
        for (int i = 1; i < NPIPE; i++) pv_q[i] <= pv_q[i-1] && !flush;
      end
    end

    always_ff @(posedge clk) begin
      pd_q[0] <= req_rsp;
      for (int i = 1; i < NPIPE; i++) pd_q[i] <= pd_q[i-1];
    end

    assign tail_vld = pv_q[NPIPE-1];
    assign tail_rsp = pd_q[NPIPE-1];
  end

  always_comb begin
    // During flush the tail is only live when it is this cycle's own request.
    tail_take   = tail_vld && (!flush || (LATENCY == 1));
    out_free    = !rsp_valid_q || pop_hs || flush;
    q_empty     = fifo_empty || flush;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    if (out_free) begin
      if (!q_empty) begin
        rsp_valid_d = 1'b1;
        rsp_d       = fifo_rdata;
        fifo_pop    = 1'b1;
        fifo_push   = tail_take;
      end else begin
        rsp_valid_d = tail_take;
        if (tail_take) rsp_d = tail_rsp;
      end
    end else begin
      fifo_push = tail_take;
    end

    if (flush) count_d = CW'(accept);
    else       count_d = count_q + CW'(accept) - CW'(pop_hs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  imem_fetch_responder_sync_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(QUEUE_DEPTH)
  ) u_rsp_queue (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .flush_i(flush),
    .wdata_i(tail_rsp),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic        hold_err;

  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00A0_0113;
  localparam logic [31:0] I2  = 32'h00B0_0193;
  localparam logic [31:0] NOP = 32'h0000_0013;

  imem_fetch_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (2),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
        chk("hold_data", rsp_data, hold_data);
        chk("hold_err", {31'b0, rsp_err}, {31'b0, hold_err});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data %h err %0d, expected no response", rsp_data, rsp_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
        end
      end
      hold_pend = rsp_valid && !rsp_ready && !flush;
      hold_data = rsp_data;
      hold_err  = rsp_err;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] ed, input logic ee);
    logic acc;
    exp_t x;
    acc = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (acc) begin
      x.d = ed;
      x.e = ee;
      sb.push_back(x);
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: addr %h not accepted, expected accept within 40 cycles", a);
    end
  endtask

  task automatic do_flush(input logic with_req, input logic [31:0] a, input logic [31:0] ed);
    logic acc;
    exp_t x;
    flush     = 1'b1;
    req_valid = with_req;
    req_addr  = a;
    @(negedge clk);
    acc = with_req && req_ready;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    if (acc) begin
      x.d = ed;
      x.e = 1'b0;
      sb.push_back(x);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    idle(2);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    idle(1);

    load(32'h0, I0);
    load(32'h4, I1);
    load(32'h8, I2);
    // Out of range: must not alias onto word 0.
    load(32'h400, 32'hDEAD_BEEF);

    // 1: single fetch, latency 2
    issue(32'h0, I0, 1'b0);
    chk("t1_valid_early", {31'b0, rsp_valid}, 32'd0);
    idle(1);
    chk("t1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t1_data", rsp_data, I0);
    chk("t1_err", {31'b0, rsp_err}, 32'd0);
    idle(3);

    // 2: back-to-back fetches, order checked by the monitor
    issue(32'h0, I0, 1'b0);
    issue(32'h4, I1, 1'b0);
    issue(32'h8, I2, 1'b0);
    idle(5);

    // 3: backpressure fills the slots, then a single pop frees one
    rsp_ready = 1'b0;
    issue(32'h4, I1, 1'b0);
    issue(32'h8, I2, 1'b0);
    chk("t3_full_ready", {31'b0, req_ready}, 32'd0);
    idle(3);
    chk("t3_hold_data", rsp_data, I1);
    chk("t3_hold_ready", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    idle(1);
    rsp_ready = 1'b0;
    chk("t3_ready_after_pop", {31'b0, req_ready}, 32'd1);
    chk("t3_next_data", rsp_data, I2);
    idle(2);
    rsp_ready = 1'b1;
    idle(3);

    // 4: error responses keep their place in the order
    issue(32'h6, NOP, 1'b1);
    issue(32'h400, NOP, 1'b1);
    issue(32'h8000_0000, NOP, 1'b1);
    issue(32'h0, I0, 1'b0);
    idle(5);

    // Load and read of the same word in one cycle returns the old word
    load_en   = 1'b1;
    load_addr = 32'h8;
    load_data = 32'h1234_5678;
    issue(32'h8, I2, 1'b0);
    load_en = 1'b0;
    issue(32'h8, 32'h1234_5678, 1'b0);
    idle(5);

    // 5a: two outstanding, flush, then a new request; only its response appears
    rsp_ready = 1'b0;
    issue(32'h0, I0, 1'b0);
    issue(32'h4, I1, 1'b0);
    do_flush(1'b0, 32'h0, 32'h0);
    chk("t5a_valid_after_flush", {31'b0, rsp_valid}, 32'd0);
    chk("t5a_ready_after_flush", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    issue(32'h1234_5678 & 32'h0, I0, 1'b0);
    idle(5);

    // 5b: request accepted in the flush cycle survives, count becomes 1
    rsp_ready = 1'b0;
    issue(32'h4, I1, 1'b0);
    idle(2);
    do_flush(1'b1, 32'h8, 32'h1234_5678);
    chk("t5b_valid_after_flush", {31'b0, rsp_valid}, 32'd0);
    issue(32'h4, I1, 1'b0);
    chk("t5b_count_two", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    idle(5);

    // 6: asynchronous reset with two outstanding; RAM survives
    rsp_ready = 1'b0;
    issue(32'h0, I0, 1'b0);
    issue(32'h4, I1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, rsp_valid}, 32'd0);
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    chk("t6_ready_release", {31'b0, req_ready}, 32'd1);
    chk("t6_valid_release", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    issue(32'h0, I0, 1'b0);
    idle(1);
    chk("t6_ram_kept", rsp_data, I0);

    for (int t = 0; t < 30 && sb.size() > 0; t++) @(posedge clk);
    idle(2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
